axil_regfile_slave: RTL

AXI-Lite slave register file that terminates one master port of the AXI-Lite bus (the m1/m2 side) and holds NUM_REGS word registers. It accepts write address and write data in either order, applies byte strobes, and returns a write response. It serves single-beat reads with a registered data path and exports all register contents to downstream logic.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/axil_addr_decode.sv | 23 ++
 rtl/axil_regfile_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared response codes and FSM state types for the AXI-Lite register file slave.
package regfile_pkg;

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } write_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } read_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decode: word-aligned offset from BASE_ADDR -> hit flag and word index.
module axil_addr_decode #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WORDS  = 8,
    parameter int BASE_ADDR  = 0,
    parameter int IDX_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index
);

    localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(4 * NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    logic [ADDR_WIDTH-1:0] offset;

    // Subtraction wraps modulo 2^ADDR_WIDTH, so addresses below the base fall far out of range.
    assign offset = addr - BASE;
    assign hit    = (offset[1:0] == 2'b00) && ({1'b0, offset} < LIMIT);
    assign index  = IDX_W'(offset >> 2);

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI-Lite slave register file with independent write/read channels and flat register export.
// Optional feature: define REGFILE_WRCNT_EN to add a read-only committed-write counter at offset 4*NUM_REGS.
module axil_regfile_slave
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int NB = DATA_WIDTH / 8;
`ifdef REGFILE_WRCNT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int IDX_W  = (NUM_REGS + EXTRA > 1) ? $clog2(NUM_REGS + EXTRA) : 1;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [RESP_WIDTH-1:0] OKAY_R   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR_R = RESP_WIDTH'(RESP_SLVERR);

    write_state_t write_state_reg, write_state_next;
    read_state_t  read_state_reg, read_state_next;

    logic                  ready_en_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg, wr_addr;
    logic [DATA_WIDTH-1:0] wdata_reg, wr_data;
    logic [NB-1:0]         wstrb_reg, wr_strb;
    logic [RESP_WIDTH-1:0] bresp_reg, rresp_reg;
    logic [DATA_WIDTH-1:0] rdata_reg, rd_word;
    logic                  aw_ready, w_ready, ar_ready, commit;
    logic                  wr_hit, wr_ok, rd_hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] regs_w [NUM_REGS];
    logic                  unused_wstrb_msb;

    assign unused_wstrb_msb = s_axi_wstrb[NB];

    // Readies stay low through reset and rise on the first edge after release.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) ready_en_reg <= 1'b0;
        else              ready_en_reg <= 1'b1;
    end

    // Address/data come straight from the bus unless captured by an earlier handshake.
    assign wr_addr = (write_state_reg == W_HAVE_ADDR) ? awaddr_reg : s_axi_awaddr;
    assign wr_data = (write_state_reg == W_HAVE_DATA) ? wdata_reg  : s_axi_wdata;
    assign wr_strb = (write_state_reg == W_HAVE_DATA) ? wstrb_reg  : s_axi_wstrb[NB-1:0];

    axil_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_REGS + EXTRA),
        .BASE_ADDR(BASE_ADDR),   .IDX_W(IDX_W)
    ) u_wr_decode (
        .addr(wr_addr), .hit(wr_hit), .index(wr_idx)
    );

    axil_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_WORDS(NUM_REGS + EXTRA),
        .BASE_ADDR(BASE_ADDR),   .IDX_W(IDX_W)
    ) u_rd_decode (
        .addr(s_axi_araddr), .hit(rd_hit), .index(rd_idx)
    );

`ifdef REGFILE_WRCNT_EN
    logic [DATA_WIDTH-1:0] wr_cnt_reg;
    assign wr_ok = wr_hit && (wr_idx != IDX_W'(NUM_REGS));

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset)          wr_cnt_reg <= '0;
        else if (commit && wr_ok)  wr_cnt_reg <= wr_cnt_reg + DATA_WIDTH'(1);
    end
`else
    assign wr_ok = wr_hit;
`endif

    always_comb begin
        write_state_next = write_state_reg;
        aw_ready         = 1'b0;
        w_ready          = 1'b0;
        commit           = 1'b0;
        case (write_state_reg)
            W_IDLE: begin
                aw_ready = ready_en_reg;
                w_ready  = ready_en_reg;
                if (ready_en_reg && s_axi_awvalid && s_axi_wvalid) begin
                    write_state_next = W_RESP;
                    commit           = 1'b1;
                end else if (ready_en_reg && s_axi_awvalid) begin
                    write_state_next = W_HAVE_ADDR;
                end else if (ready_en_reg && s_axi_wvalid) begin
                    write_state_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                w_ready = 1'b1;
                if (s_axi_wvalid) begin
                    write_state_next = W_RESP;
                    commit           = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                aw_ready = 1'b1;
                if (s_axi_awvalid) begin
                    write_state_next = W_RESP;
                    commit           = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi_bready) write_state_next = W_IDLE;
            end
            default: write_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            write_state_reg <= W_IDLE;
            awaddr_reg      <= '0;
            wdata_reg       <= '0;
            wstrb_reg       <= '0;
            bresp_reg       <= '0;
        end else begin
            write_state_reg <= write_state_next;
            if (aw_ready && s_axi_awvalid) awaddr_reg <= s_axi_awaddr;
            if (w_ready && s_axi_wvalid) begin
                wdata_reg <= s_axi_wdata;
                wstrb_reg <= s_axi_wstrb[NB-1:0];
            end
            if (commit) bresp_reg <= wr_ok ? OKAY_R : SLVERR_R;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] data_reg;
            always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
                if (s_axi_areset) begin
                    data_reg <= '0;
                end else if (commit && wr_ok && (wr_idx[RIDX_W-1:0] == RIDX_W'(gi))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_strb[b]) data_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
            assign regs_w[gi]                             = data_reg;
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
`ifdef REGFILE_WRCNT_EN
            if (rd_idx == IDX_W'(NUM_REGS)) rd_word = wr_cnt_reg;
            else                            rd_word = regs_w[rd_idx[RIDX_W-1:0]];
`else
            rd_word = regs_w[rd_idx];
`endif
        end
    end

    always_comb begin
        read_state_next = read_state_reg;
        ar_ready        = 1'b0;
        case (read_state_reg)
            R_IDLE: begin
                ar_ready = ready_en_reg;
                if (ready_en_reg && s_axi_arvalid) read_state_next = R_DATA;
            end
            R_DATA: begin
                if (s_axi_rready) read_state_next = R_IDLE;
            end
            default: read_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            read_state_reg <= R_IDLE;
            rdata_reg      <= '0;
            rresp_reg      <= '0;
        end else begin
            read_state_reg <= read_state_next;
            if (ar_ready && s_axi_arvalid) begin
                rdata_reg <= rd_word;
                rresp_reg <= rd_hit ? OKAY_R : SLVERR_R;
            end
        end
    end

    assign s_axi_awready = aw_ready;
    assign s_axi_wready  = w_ready;
    assign s_axi_bvalid  = (write_state_reg == W_RESP);
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_arready = ar_ready;
    assign s_axi_rvalid  = (read_state_reg == R_DATA);
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;

endmodule
